// File: rtl/logic_stage_pkg.sv
// Shared mode encodings and the bitwise 3-input function used by logic_stage_pipe.
package logic_stage_pkg;

    // Widest operand logic_eval supports; callers zero-extend and truncate.
    localparam int unsigned EVAL_W = 64;

    localparam logic [1:0] MODE_LEGACY = 2'd0;
    localparam logic [1:0] MODE_AND3   = 2'd1;
    localparam logic [1:0] MODE_OR3    = 2'd2;
    localparam logic [1:0] MODE_XOR3   = 2'd3;

    function automatic logic [EVAL_W-1:0] logic_eval(
        input logic [1:0]        mode,
        input logic [EVAL_W-1:0] a,
        input logic [EVAL_W-1:0] b,
        input logic [EVAL_W-1:0] c
    );
        logic [EVAL_W-1:0] res;
        case (mode)
            MODE_AND3: res = a & b & c;
            MODE_OR3:  res = a | b | c;
            MODE_XOR3: res = a ^ b ^ c;
            default:   res = a | ~(b ^ c);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/logic_pipe_slice.sv
// One valid/ready register slice holding {valid, data}; flushable by clear.
module logic_pipe_slice #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready_c,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    // Slot can load when empty or when its occupant leaves this cycle.
    assign in_ready_c = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (clear) begin
                out_valid <= 1'b0;
            end else if (in_ready_c) begin
                out_valid <= in_valid;
            end
            // Data only moves with a real beat; otherwise it keeps its stale value.
            if (in_valid && in_ready_c && !clear) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/logic_stage_pipe.sv
// Selectable 3-input bitwise function feeding a DEPTH-stage valid/ready pipeline,
// with a saturating count of delivered beats.
module logic_stage_pipe
    import logic_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] beat_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] eval_c;

    assign eval_c = WIDTH'(logic_eval(mode, EVAL_W'(a), EVAL_W'(b), EVAL_W'(c)));

    // Each stage keeps its own nets so the ready chain has no self-referencing vector.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             slot_valid;
        logic [WIDTH-1:0] slot_data;
        logic             slot_ready_c;
        logic             feed_valid;
        logic [WIDTH-1:0] feed_data;
        logic             drain_ready;

        if (k == 0) begin : g_head
            assign feed_valid = in_valid & ~clear;
            assign feed_data  = eval_c;
        end else begin : g_body
            assign feed_valid = g_stage[k-1].slot_valid;
            assign feed_data  = g_stage[k-1].slot_data;
        end

        if (k == DEPTH - 1) begin : g_tail
            assign drain_ready = out_ready;
        end else begin : g_link
            assign drain_ready = g_stage[k+1].slot_ready_c;
        end

        logic_pipe_slice #(
            .WIDTH(WIDTH)
        ) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (clear),
            .in_valid  (feed_valid),
            .in_data   (feed_data),
            .in_ready_c(slot_ready_c),
            .out_valid (slot_valid),
            .out_data  (slot_data),
            .out_ready (drain_ready)
        );
    end

    assign in_ready  = ~clear & g_stage[0].slot_ready_c;
    assign out_valid = g_stage[DEPTH-1].slot_valid;
    assign out_data  = g_stage[DEPTH-1].slot_data;

    // Delivered-beat counter; a handshake during clear is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count <= '0;
        end else if (clear) begin
            beat_count <= '0;
        end else if (out_valid && out_ready && (beat_count != CNT_MAX)) begin
            beat_count <= beat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_stage_pipe.sv
// Directed and random checks of logic_stage_pipe against an elastic-pipe reference model.
module tb_logic_stage_pipe;

    localparam int DEPTH  = 2;
    localparam int CNTMAX = 15;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b, c;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] beat_count;

    logic_stage_pipe #(
        .WIDTH(8),
        .DEPTH(DEPTH),
        .CNT_W(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .beat_count(beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: queue of in-flight beats with their stage position (0 = just accepted).
    typedef struct {
        logic [7:0] d;
        int         pos;
    } beat_t;

    beat_t      q[$];
    int         cnt_m;
    logic [7:0] got[$];
    logic       last_rdy;
    int         n_asserts;
    int         n_fail;

    function automatic logic [7:0] ref_fn(input logic [1:0] m, input logic [7:0] x,
                                          input logic [7:0] y, input logic [7:0] z);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            case (m)
                2'd0:    r[i] = x[i] | (y[i] == z[i]);
                2'd1:    r[i] = x[i] & y[i] & z[i];
                2'd2:    r[i] = x[i] | y[i] | z[i];
                default: r[i] = ((int'(x[i]) + int'(y[i]) + int'(z[i])) % 2) == 1;
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check at the falling edge, advance the model, cross the rising edge.
    task automatic cycle(input logic iv, input logic [1:0] md, input logic [7:0] ia,
                         input logic [7:0] ib, input logic [7:0] ic, input logic ordy,
                         input logic clr);
        beat_t nq[$];
        beat_t nb;
        logic  exp_v;
        logic  exp_r;
        logic  drain;
        in_valid  = iv;
        mode      = md;
        a         = ia;
        b         = ib;
        c         = ic;
        out_ready = ordy;
        clear     = clr;
        @(negedge clk);
        exp_v = (q.size() > 0) && (q[0].pos == DEPTH - 1);
        drain = exp_v && ordy && !clr;
        nq = q;
        if (exp_v && ordy) nq.pop_front();
        for (int i = 0; i < nq.size(); i++) begin
            int lim;
            lim = (i == 0) ? DEPTH - 1 : nq[i-1].pos - 1;
            nq[i].pos = (nq[i].pos + 1 < lim) ? nq[i].pos + 1 : lim;
        end
        exp_r = !clr && ((nq.size() == 0) || (nq[nq.size()-1].pos >= 1));
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        if (exp_v) chk("out_data", 32'(out_data), 32'(q[0].d));
        chk("in_ready", 32'(in_ready), 32'(exp_r));
        chk("beat_count", 32'(beat_count), 32'(cnt_m));
        last_rdy = in_ready;
        if (drain) got.push_back(out_data);
        if (clr) begin
            q.delete();
            cnt_m = 0;
        end else begin
            if (drain && cnt_m < CNTMAX) cnt_m++;
            q = nq;
            if (iv && exp_r) begin
                nb.d   = ref_fn(md, ia, ib, ic);
                nb.pos = 0;
                q.push_back(nb);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        cnt_m     = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        mode      = 2'd0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 8'hFF;
        b         = 8'hFF;
        c         = 8'hFF;

        // Reset held with a beat offered.
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_beat_count", 32'(beat_count), 32'd0);
        #10;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // All four functions on back-to-back beats.
        got.delete();
        cycle(1'b1, 2'd0, 8'hF0, 8'hCC, 8'hAA, 1'b1, 1'b0);
        cycle(1'b1, 2'd1, 8'hF0, 8'hCC, 8'hAA, 1'b1, 1'b0);
        cycle(1'b1, 2'd2, 8'hF0, 8'hCC, 8'hAA, 1'b1, 1'b0);
        cycle(1'b1, 2'd3, 8'hF0, 8'hCC, 8'hAA, 1'b1, 1'b0);
        idle(3);
        chk("func_count", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            chk("legacy_f9", 32'(got[0]), 32'hF9);
            chk("and3_80", 32'(got[1]), 32'h80);
            chk("or3_fe", 32'(got[2]), 32'hFE);
            chk("xor3_96", 32'(got[3]), 32'h96);
        end

        // Backpressure: two beats fill the pipe, third waits then passes through.
        got.delete();
        cycle(1'b1, 2'd1, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 2'd1, 8'h02, 8'h02, 8'h02, 1'b0, 1'b0);
        cycle(1'b1, 2'd1, 8'h03, 8'h03, 8'h03, 1'b0, 1'b0);
        chk("bp_ready_low", 32'(last_rdy), 32'd0);
        cycle(1'b1, 2'd1, 8'h03, 8'h03, 8'h03, 1'b1, 1'b0);
        chk("bp_passthru", 32'(last_rdy), 32'd1);
        idle(3);
        chk("bp_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("bp_seq0", 32'(got[0]), 32'h01);
            chk("bp_seq1", 32'(got[1]), 32'h02);
            chk("bp_seq2", 32'(got[2]), 32'h03);
        end

        // Clear with the pipe full and a beat offered.
        got.delete();
        cycle(1'b1, 2'd2, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, 8'h22, 8'h00, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, 8'h33, 8'h00, 8'h00, 1'b1, 1'b1);
        chk("clr_ready_low", 32'(last_rdy), 32'd0);
        idle(3);
        chk("clr_nothing_out", 32'(got.size()), 32'd0);
        chk("clr_count_zero", 32'(beat_count), 32'd0);

        // Counter saturation: 17 deliveries into a 4-bit counter.
        for (int i = 0; i < 17; i++) cycle(1'b1, 2'd3, 8'(i), 8'h5A, 8'hC3, 1'b1, 1'b0);
        idle(2);
        chk("sat_count", 32'(beat_count), 32'hF);

        // Random traffic, modes, stalls and occasional clears.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        end
        idle(3);

        // Asynchronous reset while full.
        cycle(1'b1, 2'd0, 8'h0F, 8'h0F, 8'h0F, 1'b0, 1'b0);
        cycle(1'b1, 2'd0, 8'hF0, 8'h0F, 8'h0F, 1'b0, 1'b0);
        chk("full_before_arst", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_beat_count", 32'(beat_count), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'h00);
        q.delete();
        cnt_m = 0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);
        cycle(1'b1, 2'd2, 8'h40, 8'h02, 8'h01, 1'b1, 1'b0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
